// File: rtl/pwr_switch_ack_if.sv
// Power-switch request/acknowledge bundle between a controller (master) and the
// switch acknowledge model (slave).
interface pwr_switch_ack_if #(
  parameter int N_DOMAINS = 1
);
  logic [N_DOMAINS-1:0] switch_n_i;
  logic [N_DOMAINS-1:0] switch_ack_n_o;
  logic [N_DOMAINS-1:0] busy_o;
  logic [N_DOMAINS-1:0] abort_o;
  logic [15:0]          abort_cnt_o;

  modport master (
    output switch_n_i,
    input  switch_ack_n_o,
    input  busy_o,
    input  abort_o,
    input  abort_cnt_o
  );

  modport slave (
    input  switch_n_i,
    output switch_ack_n_o,
    output busy_o,
    output abort_o,
    output abort_cnt_o
  );
endinterface

// File: rtl/pwr_switch_ack_model.sv
// Behavioural power-switch acknowledge model: per-domain ramp FSM with fixed ack latency.
// Optional saturating abort counter enabled by macro PWR_SWITCH_ACK_ABORT_CNT_EN.
module pwr_switch_ack_model #(
  parameter int N_DOMAINS   = 1,
  parameter int ACK_LATENCY = 15
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  pwr_switch_ack_if.slave        bus
);

  typedef enum logic [1:0] {
    ST_ON       = 2'd0,
    ST_RAMP_OFF = 2'd1,
    ST_OFF      = 2'd2,
    ST_RAMP_ON  = 2'd3
  } state_e;

  localparam logic [7:0] CNT_LOAD = 8'(ACK_LATENCY - 1);

  state_e               state_q [N_DOMAINS];
  state_e               state_d [N_DOMAINS];
  logic [7:0]           cnt_q   [N_DOMAINS];
  logic [7:0]           cnt_d   [N_DOMAINS];
  logic [N_DOMAINS-1:0] ack_n_q, ack_n_d;
  logic [N_DOMAINS-1:0] busy_q, busy_d;
  logic [N_DOMAINS-1:0] abort_q, abort_d;

  // A request reversal during a ramp wins over ramp completion.
  always_comb begin
    ack_n_d = '0;
    busy_d  = '0;
    abort_d = '0;
    for (int d = 0; d < N_DOMAINS; d++) begin
      state_d[d] = state_q[d];
      cnt_d[d]   = cnt_q[d];
      case (state_q[d])
        ST_ON: begin
          if (bus.switch_n_i[d]) begin
            state_d[d] = ST_RAMP_OFF;
            cnt_d[d]   = CNT_LOAD;
          end
        end
        ST_OFF: begin
          if (!bus.switch_n_i[d]) begin
            state_d[d] = ST_RAMP_ON;
            cnt_d[d]   = CNT_LOAD;
          end
        end
        ST_RAMP_OFF: begin
          if (!bus.switch_n_i[d]) begin
            state_d[d] = ST_ON;
            cnt_d[d]   = 8'd0;
            abort_d[d] = 1'b1;
          end else if (cnt_q[d] == 8'd0) begin
            state_d[d] = ST_OFF;
          end else begin
            cnt_d[d] = cnt_q[d] - 8'd1;
          end
        end
        ST_RAMP_ON: begin
          if (bus.switch_n_i[d]) begin
            state_d[d] = ST_OFF;
            cnt_d[d]   = 8'd0;
            abort_d[d] = 1'b1;
          end else if (cnt_q[d] == 8'd0) begin
            state_d[d] = ST_ON;
          end else begin
            cnt_d[d] = cnt_q[d] - 8'd1;
          end
        end
      endcase
      ack_n_d[d] = (state_d[d] == ST_OFF) || (state_d[d] == ST_RAMP_ON);
      busy_d[d]  = (state_d[d] == ST_RAMP_OFF) || (state_d[d] == ST_RAMP_ON);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int d = 0; d < N_DOMAINS; d++) begin
        state_q[d] <= ST_ON;
        cnt_q[d]   <= 8'd0;
      end
      ack_n_q <= '0;
      busy_q  <= '0;
      abort_q <= '0;
    end else begin
      for (int d = 0; d < N_DOMAINS; d++) begin
        state_q[d] <= state_d[d];
        cnt_q[d]   <= cnt_d[d];
      end
      ack_n_q <= ack_n_d;
      busy_q  <= busy_d;
      abort_q <= abort_d;
    end
  end

  assign bus.switch_ack_n_o = ack_n_q;
  assign bus.busy_o         = busy_q;
  assign bus.abort_o        = abort_q;

`ifdef PWR_SWITCH_ACK_ABORT_CNT_EN
  function automatic logic [5:0] popcount(input logic [N_DOMAINS-1:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < N_DOMAINS; i++) c = c + 6'(v[i]);
    return c;
  endfunction

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [5:0] b);
    logic [16:0] s;
    s = {1'b0, a} + 17'(b);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  logic [15:0] abort_cnt_q, abort_cnt_d;

  always_comb abort_cnt_d = sat_add(abort_cnt_q, popcount(abort_d));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) abort_cnt_q <= '0;
    else         abort_cnt_q <= abort_cnt_d;
  end

  assign bus.abort_cnt_o = abort_cnt_q;
`else
  assign bus.abort_cnt_o = 16'h0000;
`endif

endmodule
